// File: rtl/mips_muldiv_if.sv
// Handshake and operand/result bundle between the control unit / datapath
// and the multi-cycle multiply/divide unit.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [1:0]       MDOP;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  logic             BUSY;
  logic             DONE;
  logic             DIVZERO;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  // Control unit side: issues operations, observes status and HI/LO.
  modport master (
    output START, MDOP, ReadData1, ReadData2,
    input  BUSY, DONE, DIVZERO, HI, LO
  );

  // Multiply/divide unit side.
  modport slave (
    input  START, MDOP, ReadData1, ReadData2,
    output BUSY, DONE, DIVZERO, HI, LO
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes (shift-add multiply, restoring divide)
// and get their signs restored in a single FIXUP cycle, so the latency is
// always WIDTH+1 cycles from the accepting edge to DONE.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  mips_muldiv_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // Absolute value of an operand; unsigned operations pass through untouched.
  // The most negative value maps onto itself, which is its correct unsigned
  // magnitude.
  function automatic logic [WIDTH-1:0] magnitude(
    input logic signed [WIDTH-1:0] v,
    input logic                    is_signed
  );
    logic signed [WIDTH-1:0] neg_v;
    neg_v = -v;
    return (is_signed && (v < 0)) ? $unsigned(neg_v) : $unsigned(v);
  endfunction

  // Two's-complement sign correction of a single result word.
  function automatic logic [WIDTH-1:0] apply_sign(
    input logic [WIDTH-1:0] v,
    input logic             neg
  );
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Two's-complement sign correction of the full double-width product.
  function automatic logic [2*WIDTH-1:0] apply_sign_wide(
    input logic [2*WIDTH-1:0] v,
    input logic               neg
  );
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_lo;     // product sign, or quotient sign
  logic               neg_hi;     // remainder sign (dividend sign)
  logic               div_by_zero;
  logic [WIDTH-1:0]   opb;        // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   dividend;   // original rs value, returned on divide by zero
  logic [2*WIDTH-1:0] acc;        // product accumulator, or remainder:quotient

  logic               busy_r;
  logic               done_r;
  logic               divzero_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_wide;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_keep;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;

  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;
  assign bus.DIVZERO = divzero_r;
  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;

  // Operand preparation: record operand signs and form magnitudes for the
  // operation presented on the bus this cycle.
  always_comb begin
    sign_a = bus.MDOP[0] & bus.ReadData1[WIDTH-1];
    sign_b = bus.MDOP[0] & bus.ReadData2[WIDTH-1];
    mag_a  = magnitude($signed(bus.ReadData1), bus.MDOP[0]);
    mag_b  = magnitude($signed(bus.ReadData2), bus.MDOP[0]);
  end

  // One iteration of shift-add multiply or restoring divide on the accumulator.
  always_comb begin
    // Multiply: conditionally add the multiplicand into the upper half with a
    // carry bit, then shift the whole accumulator right by one.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    // Divide: remainder after the left shift needs one extra bit, since it
    // can exceed WIDTH bits before the trial subtraction.
    rem_wide = acc[2*WIDTH-1:WIDTH-1];
    rem_keep = (rem_wide >= {1'b0, opb});
    rem_sub  = WIDTH'(rem_wide - {1'b0, opb});
    acc_next = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_keep) begin
        acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem_wide[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
    product = apply_sign_wide(acc, neg_lo);
  end

  // Control FSM and datapath registers: accept in IDLE, iterate WIDTH times
  // in CALC, sign-correct and publish HI/LO in FIXUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      div_by_zero <= 1'b0;
      opb         <= '0;
      dividend    <= '0;
      acc         <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      divzero_r   <= 1'b0;
      hi_r        <= '0;
      lo_r        <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            is_div      <= bus.MDOP[1];
            neg_lo      <= sign_a ^ sign_b;
            neg_hi      <= sign_a;
            dividend    <= bus.ReadData1;
            div_by_zero <= bus.MDOP[1] && (bus.ReadData2 == '0);
            if (bus.MDOP[1]) begin
              opb <= mag_b;
              acc <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opb <= mag_a;
              acc <= {{WIDTH{1'b0}}, mag_b};
            end
            cnt       <= '0;
            busy_r    <= 1'b1;
            divzero_r <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (is_div) begin
            if (div_by_zero) begin
              hi_r      <= dividend;
              lo_r      <= {WIDTH{1'b1}};
              divzero_r <= 1'b1;
            end else begin
              hi_r <= apply_sign(acc[2*WIDTH-1:WIDTH], neg_hi);
              lo_r <= apply_sign(acc[WIDTH-1:0], neg_lo);
            end
          end else begin
            hi_r <= product[2*WIDTH-1:WIDTH];
            lo_r <= product[WIDTH-1:0];
          end
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for START hold, back-to-back issue and asynchronous reset.
module tb_mips_muldiv_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;

  mips_muldiv_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    vecs.push_back(v);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint unsigned pu;
    longint          sa, sb, ps, q, r;
    dz = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin pu = {32'h0, a} * {32'h0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      2'b01: begin ps = sa * sb; hi = ps[63:32]; lo = ps[31:0]; end
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and wait (bounded) for DONE; operands are scrambled
  // right after acceptance to show they are latched.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz);
    int   lat;
    logic busy_drop;
    @(negedge clk);
    bus.START = 1'b1; bus.MDOP = op; bus.ReadData1 = a; bus.ReadData2 = b;
    @(posedge clk); #1;
    check({tag, ".accept_busy"}, bus.BUSY, 1);
    check({tag, ".accept_divzero_clr"}, bus.DIVZERO, 0);
    check({tag, ".accept_done_low"}, bus.DONE, 0);
    @(negedge clk);
    bus.START = 1'b0; bus.ReadData1 = $urandom; bus.ReadData2 = $urandom;
    bus.MDOP = 2'($urandom);
    lat = 0;
    busy_drop = 1'b0;
    while (bus.DONE !== 1'b1 && lat < LAT + 6) begin
      if (bus.BUSY !== 1'b1) busy_drop = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".busy_held"}, busy_drop, 0);
    check({tag, ".done_busy_low"}, bus.BUSY, 0);
    hi = bus.HI; lo = bus.LO; dz = bus.DIVZERO;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected end before 900000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] hi, lo, ehi, elo;
    logic        dz, edz;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          lat;

    add_vec("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    add_vec("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    add_vec("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    add_vec("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    add_vec("divu_100by7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    add_vec("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    add_vec("divu_by0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    add_vec("div_neg_by0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    add_vec("div_7byneg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    add_vec("multu_5x6", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

    // Reset state
    rst_n = 1'b0;
    bus.START = 1'b0; bus.MDOP = 2'b00; bus.ReadData1 = '0; bus.ReadData2 = '0;
    #1;
    check("reset.busy", bus.BUSY, 0);
    check("reset.done", bus.DONE, 0);
    check("reset.divzero", bus.DIVZERO, 0);
    check("reset.hi", bus.HI, 0);
    check("reset.lo", bus.LO, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table; successive entries issue on the DONE cycle of the previous
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz);
      check({vecs[i].name, ".hi"}, hi, vecs[i].hi);
      check({vecs[i].name, ".lo"}, lo, vecs[i].lo);
      check({vecs[i].name, ".divzero"}, dz, vecs[i].dz);
    end
    @(posedge clk); #1;
    check("done_single_cycle", bus.DONE, 0);
    check("hold_hi", bus.HI, 0);
    check("hold_lo", bus.LO, 30);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      model(op, a, b, ehi, elo, edz);
      run_op($sformatf("rand%0d_op%0d", n, op), op, a, b, hi, lo, dz);
      if (hi !== ehi || lo !== elo || dz !== edz)
        $display("  operands op=%0d a=%h b=%h", op, a, b);
      check($sformatf("rand%0d.hi", n), hi, ehi);
      check($sformatf("rand%0d.lo", n), lo, elo);
      check($sformatf("rand%0d.divzero", n), dz, edz);
    end

    // START held through the whole run with operands changing every cycle
    @(negedge clk);
    bus.START = 1'b1; bus.MDOP = 2'b00; bus.ReadData1 = 32'd3; bus.ReadData2 = 32'd4;
    @(posedge clk); #1;
    check("hold.accept_busy", bus.BUSY, 1);
    lat = 0;
    while (bus.DONE !== 1'b1 && lat < LAT + 6) begin
      @(negedge clk);
      bus.ReadData1 = $urandom; bus.ReadData2 = $urandom; bus.MDOP = 2'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("hold.latency", lat, LAT);
    check("hold.hi", bus.HI, 0);
    check("hold.lo", bus.LO, 12);
    @(negedge clk);
    bus.START = 1'b0;
    @(posedge clk); #1;
    check("hold.no_requeue", bus.BUSY, 0);

    // Reset in the middle of CALC clears outputs without a clock edge
    run_op("pre_reset", 2'b00, 32'd7, 32'd9, hi, lo, dz);
    check("pre_reset.lo", lo, 63);
    @(negedge clk);
    bus.START = 1'b1; bus.MDOP = 2'b00;
    bus.ReadData1 = 32'hFFFF_FFFF; bus.ReadData2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.busy", bus.BUSY, 0);
    check("midreset.done", bus.DONE, 0);
    check("midreset.hi", bus.HI, 0);
    check("midreset.lo", bus.LO, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset.idle", bus.BUSY, 0);
    run_op("postreset", 2'b00, 32'd5, 32'd6, hi, lo, dz);
    check("postreset.hi", hi, 0);
    check("postreset.lo", lo, 30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
